// File: rtl/fp_fixed_pkg.sv
// Shared types and constants for the float-to-fixed conversion path.
// Default-format constants describe IEEE-754 binary32.
package fp_fixed_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam int FW        = 1 + EXP_W_DEF + MAN_W_DEF;
  localparam int BIAS      = 2**(EXP_W_DEF-1) - 1;

  localparam logic RM_TRUNC = 1'b0;
  localparam logic RM_RNE   = 1'b1;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_DEN,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  function automatic fp_class_e classify(input logic exp_zero,
                                         input logic exp_ones,
                                         input logic man_zero);
    if (exp_zero) return man_zero ? CLS_ZERO : CLS_DEN;
    if (exp_ones) return man_zero ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Rounds an unsigned magnitude with guard/sticky, applies sign and saturates
// into a signed OUT_W-bit result. Purely combinational.
module fixed_round_sat
  import fp_fixed_pkg::*;
#(
  parameter int MAG_W = 33,
  parameter int OUT_W = 32
) (
  input  logic             sign,
  input  logic [MAG_W-1:0] mag,
  input  logic             guard,
  input  logic             sticky,
  input  logic             ovf_in,
  input  logic             round_mode,
  output logic [OUT_W-1:0] result,
  output logic             ovf,
  output logic             inexact
);

  localparam int RW = MAG_W + 1;

  logic             inc;
  logic [RW-1:0]    mag_r;
  logic [RW-1:0]    lim;
  logic [OUT_W-1:0] low;
  logic [OUT_W-1:0] sat_val;

  assign inc   = (round_mode == RM_RNE) & guard & (sticky | mag[0]);
  assign mag_r = RW'(mag) + RW'(inc);

  // Negative side may reach exactly 2**(OUT_W-1); positive side stops one short.
  assign lim = sign ? (RW'(1) << (OUT_W-1)) : ((RW'(1) << (OUT_W-1)) - RW'(1));

  assign ovf     = ovf_in | (mag_r > lim);
  assign inexact = guard | sticky;

  assign low     = mag_r[OUT_W-1:0];
  assign sat_val = sign ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};

  assign result = ovf  ? sat_val :
                  sign ? (~low + OUT_W'(1)) : low;

endmodule

// File: rtl/float_to_fixed_pipe.sv
// Three-stage pipelined IEEE-754 float to signed fixed-point converter with
// valid/ready flow control: S1 unpack, S2 align, S3 round/saturate.
module float_to_fixed_pipe
  import fp_fixed_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int OUT_W = 32,
  parameter int POS_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   float,
  input  logic [POS_W-1:0]       fixpointpos,
  input  logic                   round_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       result,
  output logic                   flag_ovf,
  output logic                   flag_inexact,
  output logic                   flag_invalid
);

  localparam int EXP_BIAS = 2**(EXP_W-1) - 1;
  localparam int SH_W     = EXP_W + 2;
  localparam int SIG_W    = MAN_W + 1;
  localparam int MAG_W    = OUT_W + 1;
  localparam int LW       = MAG_W + SIG_W;
  localparam int RW       = SIG_W + MAN_W + 3;
  localparam int MAX_R    = MAN_W + 2;

  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // ---------------- S1: unpack ----------------
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_man;
  fp_class_e        in_cls;
  logic [SH_W-1:0]  in_sh;

  assign {in_sign, in_exp, in_man} = float;
  assign in_cls = classify(in_exp == '0, &in_exp, in_man == '0);
  assign in_sh  = SH_W'(in_exp) - SH_W'(EXP_BIAS) + SH_W'(fixpointpos) - SH_W'(MAN_W);

  logic             s1_valid, s1_sign, s1_rm;
  fp_class_e        s1_cls;
  logic [SIG_W-1:0] s1_sig;
  logic [SH_W-1:0]  s1_sh;

  // ---------------- S2: align ----------------
  logic             sh_neg;
  logic [SH_W-1:0]  sh_abs;
  logic [LW-1:0]    lwide;
  logic [RW-1:0]    rwide;
  logic             left_ovf;
  logic             far_right;

  assign sh_neg    = s1_sh[SH_W-1];
  assign sh_abs    = sh_neg ? -s1_sh : s1_sh;
  assign lwide     = LW'(s1_sig) << sh_abs;
  assign rwide     = {s1_sig, {(MAN_W+3){1'b0}}} >> sh_abs;
  assign left_ovf  = (sh_abs > SH_W'(OUT_W)) | (|lwide[LW-1:MAG_W]);
  assign far_right = sh_abs > SH_W'(MAX_R);

  logic [MAG_W-1:0] a_mag;
  logic             a_guard, a_sticky, a_ovf, a_invalid;

  // NOTE: every output gets a default first so no path through the case leaves a latch.
  always_comb begin
    a_mag     = '0;
    a_guard   = 1'b0;
    a_sticky  = 1'b0;
    a_ovf     = 1'b0;
    a_invalid = 1'b0;
    case (s1_cls)
      CLS_NORM: begin
        if (!sh_neg) begin
          a_mag = lwide[MAG_W-1:0];
          a_ovf = left_ovf;
        end else if (far_right) begin
          a_sticky = 1'b1;
        end else begin
          a_mag    = MAG_W'(rwide[RW-1:MAN_W+3]);
          a_guard  = rwide[MAN_W+2];
          a_sticky = |rwide[MAN_W+1:0];
        end
      end
      CLS_DEN: a_sticky  = 1'b1;   // flushed to zero, but value was nonzero
      CLS_INF: a_ovf     = 1'b1;
      CLS_NAN: a_invalid = 1'b1;
      default: ;
    endcase
  end

  logic             s2_valid, s2_sign, s2_rm;
  logic [MAG_W-1:0] s2_mag;
  logic             s2_guard, s2_sticky, s2_ovf, s2_invalid;

  // ---------------- S3: round / sign / saturate ----------------
  logic [OUT_W-1:0] r_result;
  logic             r_ovf, r_inexact;

  fixed_round_sat #(
    .MAG_W (MAG_W),
    .OUT_W (OUT_W)
  ) u_round_sat (
    .sign       (s2_sign),
    .mag        (s2_mag),
    .guard      (s2_guard),
    .sticky     (s2_sticky),
    .ovf_in     (s2_ovf),
    .round_mode (s2_rm),
    .result     (r_result),
    .ovf        (r_ovf),
    .inexact    (r_inexact)
  );

  // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid     <= 1'b0;
      s1_sign      <= 1'b0;
      s1_rm        <= 1'b0;
      s1_cls       <= CLS_ZERO;
      s1_sig       <= '0;
      s1_sh        <= '0;
      s2_valid     <= 1'b0;
      s2_sign      <= 1'b0;
      s2_rm        <= 1'b0;
      s2_mag       <= '0;
      s2_guard     <= 1'b0;
      s2_sticky    <= 1'b0;
      s2_ovf       <= 1'b0;
      s2_invalid   <= 1'b0;
      out_valid    <= 1'b0;
      result       <= '0;
      flag_ovf     <= 1'b0;
      flag_inexact <= 1'b0;
      flag_invalid <= 1'b0;
    end else if (adv) begin
      s1_valid     <= in_valid;
      s1_sign      <= in_sign;
      s1_rm        <= round_mode;
      s1_cls       <= in_cls;
      s1_sig       <= {1'b1, in_man};
      s1_sh        <= in_sh;
      s2_valid     <= s1_valid;
      s2_sign      <= s1_sign;
      s2_rm        <= s1_rm;
      s2_mag       <= a_mag;
      s2_guard     <= a_guard;
      s2_sticky    <= a_sticky;
      s2_ovf       <= a_ovf;
      s2_invalid   <= a_invalid;
      out_valid    <= s2_valid;
      result       <= r_result;
      flag_ovf     <= r_ovf;
      flag_inexact <= r_inexact;
      flag_invalid <= s2_invalid;
    end
  end

endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// Directed-vector bench for float_to_fixed_pipe: per-vector latency/value checks,
// a stalled back-to-back stream, and reset while items are in flight.
module tb_float_to_fixed_pipe;
  import fp_fixed_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FW-1:0] flt = '0;
  logic [4:0]    pos = '0;
  logic          round_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   result;
  logic          flag_ovf, flag_inexact, flag_invalid;

  float_to_fixed_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .float        (flt),
    .fixpointpos  (pos),
    .round_mode   (round_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .flag_ovf     (flag_ovf),
    .flag_inexact (flag_inexact),
    .flag_invalid (flag_invalid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // flags packed as {ovf, inexact, invalid}
  typedef struct {
    logic [31:0] f;
    logic [4:0]  pos;
    logic        rm;
    logic [31:0] res;
    logic [2:0]  flags;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  function automatic logic [2:0] flags_now();
    return {flag_ovf, flag_inexact, flag_invalid};
  endfunction

  task automatic load_vec(input int i);
    flt        = vecs[i].f;
    pos        = vecs[i].pos;
    round_mode = vecs[i].rm;
  endtask

  task automatic run_single(input int i);
    int lat;
    @(negedge clk);
    load_vec(i);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check($sformatf("v%0d accept", i), in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("v%0d latency", i), lat, 3);
    check($sformatf("v%0d result", i), result, vecs[i].res);
    check($sformatf("v%0d flags", i), flags_now(), vecs[i].flags);
  endtask

  initial begin
    int q[$];
    int sent, got, cyc, idx, extra;
    logic        held_v;
    logic [31:0] held_r;

    vecs[0]  = '{{1'b0, 8'(BIAS), 23'd0}, 5'd16, RM_RNE, 32'h0001_0000, 3'b000}; // 1.0
    vecs[1]  = '{32'hBFC0_0000, 5'd16, RM_RNE,   32'hFFFE_8000, 3'b000}; // -1.5
    vecs[2]  = '{32'hCF00_0000, 5'd0,  RM_RNE,   32'h8000_0000, 3'b000}; // -2^31 exact min
    vecs[3]  = '{32'h4020_0000, 5'd0,  RM_RNE,   32'h0000_0002, 3'b010}; // 2.5 -> 2
    vecs[4]  = '{32'h4060_0000, 5'd0,  RM_RNE,   32'h0000_0004, 3'b010}; // 3.5 -> 4
    vecs[5]  = '{32'h4060_0000, 5'd0,  RM_TRUNC, 32'h0000_0003, 3'b010}; // 3.5 trunc -> 3
    vecs[6]  = '{32'h5015_02F9, 5'd0,  RM_RNE,   32'h7FFF_FFFF, 3'b100}; // 1e10
    vecs[7]  = '{32'hFF80_0000, 5'd0,  RM_RNE,   32'h8000_0000, 3'b100}; // -Inf
    vecs[8]  = '{32'h7FC0_0000, 5'd0,  RM_RNE,   32'h0000_0000, 3'b001}; // NaN
    vecs[9]  = '{32'h0000_0001, 5'd0,  RM_RNE,   32'h0000_0000, 3'b010}; // denormal
    vecs[10] = '{32'h8000_0000, 5'd0,  RM_RNE,   32'h0000_0000, 3'b000}; // -0.0
    vecs[11] = '{32'h7F80_0000, 5'd5,  RM_RNE,   32'h7FFF_FFFF, 3'b100}; // +Inf
    vecs[12] = '{32'h4F00_0000, 5'd0,  RM_RNE,   32'h7FFF_FFFF, 3'b100}; // +2^31 just out
    vecs[13] = '{32'hC020_0000, 5'd0,  RM_TRUNC, 32'hFFFF_FFFE, 3'b010}; // -2.5 trunc
    vecs[14] = '{32'h3F00_0000, 5'd0,  RM_RNE,   32'h0000_0000, 3'b010}; // 0.5 tie -> 0
    vecs[15] = '{32'h3FC0_0000, 5'd0,  RM_RNE,   32'h0000_0002, 3'b010}; // 1.5 tie -> 2
    vecs[16] = '{32'h0080_0000, 5'd31, RM_RNE,   32'h0000_0000, 3'b010}; // far right shift
    vecs[17] = '{32'hBF80_0000, 5'd31, RM_RNE,   32'h8000_0000, 3'b000}; // -1.0 Q31 = min
    vecs[18] = '{32'h3F80_0000, 5'd31, RM_RNE,   32'h7FFF_FFFF, 3'b100}; // +1.0 Q31 sat

    // reset state
    #12;
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset flags", flags_now(), 3'b000);
    check("reset in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) run_single(i);

    // back-to-back stream under random backpressure
    sent = 0; got = 0; cyc = 0; held_v = 1'b0; held_r = '0;
    while (got < 10 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (held_v) begin
        check("stall valid held", out_valid, 1);
        check("stall result held", result, held_r);
      end
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 10) begin
        load_vec((sent * 7) % NV);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) begin
        q.push_back((sent * 7) % NV);
        sent++;
      end
      held_v = out_valid && !out_ready;
      held_r = result;
      if (held_v) check("in_ready low while stalled", in_ready, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("stream spurious output", 1, 0);
        end else begin
          idx = q.pop_front();
          check($sformatf("stream item %0d result", got), result, vecs[idx].res);
          check($sformatf("stream item %0d flags", got), flags_now(), vecs[idx].flags);
        end
        got++;
      end
    end
    check("stream delivered count", got, 10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("stream no duplicates", extra, 0);

    // reset while three items are in flight and the output is stalled
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      load_vec(k);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre-reset out_valid", out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset result", result, 0);
    check("async reset flags", flags_now(), 3'b000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("in_ready after reset", in_ready, 1);
    out_ready = 1'b1;
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("no stale output after reset", extra, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
